// File: rtl/led_display_pattern_driver_pkg.sv
// Shared types, constants and helpers for the LED matrix pattern driver.
package led_display_package;

  localparam int GL_NUM_COL_PIXELS = 64;
  localparam int GL_NUM_ROW_PIXELS = 32;
  localparam int GL_ADDR_W         = 4;
  localparam int GL_COL_W          = 6;

  // One half-panel row: one bit per column per channel, column 0 in bit 0.
  typedef struct packed {
    logic [GL_NUM_COL_PIXELS-1:0] red;
    logic [GL_NUM_COL_PIXELS-1:0] green;
    logic [GL_NUM_COL_PIXELS-1:0] blue;
  } rgb_half_t;

  typedef struct packed {
    rgb_half_t top;
    rgb_half_t bot;
  } rgb_row_t;

  localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

  // Mode encodings; any other mode_in value renders as MODE_OFF.
  localparam logic [3:0] MODE_OFF     = 4'd0;
  localparam logic [3:0] MODE_SOLID   = 4'd1;
  localparam logic [3:0] MODE_DEBUG_V = 4'd2;

  localparam logic [GL_NUM_COL_PIXELS-1:0] GL_EVEN_COL_MASK = {(GL_NUM_COL_PIXELS/2){2'b01}};

  typedef enum logic [1:0] {
    PHY_IDLE  = 2'd0,
    PHY_SHIFT = 2'd1,
    PHY_LATCH = 2'd2
  } phy_state_t;

  // System-clock cycles per bit-clock phase, rounded up so BCLK_FREQ is never exceeded.
  function automatic int half_period(input int sys_clk_freq, input int bclk_freq);
    return (sys_clk_freq + 2 * bclk_freq - 1) / (2 * bclk_freq);
  endfunction

  // Pattern for one half row; the patterns do not depend on the scan address.
  function automatic rgb_half_t build_half(input logic [3:0] mode, input logic [2:0] colour);
    logic [GL_NUM_COL_PIXELS-1:0] mask;
    rgb_half_t half;
    case (mode)
      MODE_SOLID:   mask = '1;
      MODE_DEBUG_V: mask = GL_EVEN_COL_MASK;
      default:      mask = '0;
    endcase
    half.red   = colour[0] ? mask : '0;
    half.green = colour[1] ? mask : '0;
    half.blue  = colour[2] ? mask : '0;
    return half;
  endfunction

  // Six serial data bits of one column: {b_bot, g_bot, r_bot, b_top, g_top, r_top}.
  function automatic logic [5:0] column_bits(input rgb_row_t row, input logic [GL_COL_W-1:0] col);
    return {row.bot.blue[col], row.bot.green[col], row.bot.red[col],
            row.top.blue[col], row.top.green[col], row.top.red[col]};
  endfunction

endpackage

// File: rtl/led_display_driver_phy.sv
// Serial row PHY: captures an accepted row, shifts it out column 0 first, then latches it.
module led_display_driver_phy
  import led_display_package::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int BCLK_FREQ      = 21_000_000,
  parameter int NUM_COL_PIXELS = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_row_valid,
  input  rgb_row_t             i_row,
  input  logic [GL_ADDR_W-1:0] i_row_addr,
  output logic                 o_row_ready,
  output logic [5:0]           o_data,
  output logic                 o_bit_clk,
  output logic                 o_latch,
  output logic [GL_ADDR_W-1:0] o_row_addr,
  output logic [1:0]           o_state
);

  localparam int HALF = half_period(SYS_CLK_FREQ, BCLK_FREQ);
  localparam int PH_W = $clog2(2 * HALF);
  localparam logic [PH_W-1:0]     PH_RISE = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0]     PH_END  = PH_W'(2 * HALF - 1);
  localparam logic [GL_COL_W-1:0] COL_END = GL_COL_W'(NUM_COL_PIXELS - 1);

  phy_state_t           r_state;
  phy_state_t           w_state_next;
  logic                 w_ready;
  logic                 w_bit_end;
  rgb_row_t             r_row;
  logic [GL_ADDR_W-1:0] r_addr_cap;
  logic [GL_ADDR_W-1:0] r_addr_out;
  logic [PH_W-1:0]      r_phase;
  logic [GL_COL_W-1:0]  r_col;
  logic                 r_bclk;
  logic                 r_latch;
  logic [5:0]           r_data;

  assign w_bit_end   = (r_phase == PH_END);
  assign o_row_ready = w_ready;
  assign o_data      = r_data;
  assign o_bit_clk   = r_bclk;
  assign o_latch     = r_latch;
  assign o_row_addr  = r_addr_out;
  assign o_state     = r_state;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= PHY_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and ready: accept only in IDLE, one bit-clock period per column and for the latch.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      PHY_IDLE: begin
        w_ready = 1'b1;
        if (i_row_valid) w_state_next = PHY_SHIFT;
      end
      PHY_SHIFT: if (w_bit_end && (r_col == COL_END)) w_state_next = PHY_LATCH;
      PHY_LATCH: if (w_bit_end) w_state_next = PHY_IDLE;
      default:   w_state_next = PHY_IDLE;
    endcase
  end

  // Datapath: data changes together with the falling bit clock, a full phase ahead of the rise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row      <= '0;
      r_addr_cap <= '0;
      r_addr_out <= '0;
      r_phase    <= '0;
      r_col      <= '0;
      r_bclk     <= 1'b0;
      r_latch    <= 1'b0;
      r_data     <= '0;
    end else begin
      case (r_state)
        PHY_IDLE: begin
          r_phase <= '0;
          r_col   <= '0;
          if (i_row_valid) begin
            r_row      <= i_row;
            r_addr_cap <= i_row_addr;
            r_data     <= column_bits(i_row, '0);
          end
        end
        PHY_SHIFT: begin
          r_phase <= w_bit_end ? '0 : r_phase + 1'b1;
          if (r_phase == PH_RISE) r_bclk <= 1'b1;
          if (w_bit_end) begin
            r_bclk <= 1'b0;
            if (r_col == COL_END) begin
              r_latch    <= 1'b1;
              r_addr_out <= r_addr_cap;
              r_data     <= '0;
            end else begin
              r_col  <= r_col + 1'b1;
              r_data <= column_bits(r_row, r_col + 1'b1);
            end
          end
        end
        PHY_LATCH: begin
          r_phase <= w_bit_end ? '0 : r_phase + 1'b1;
          if (w_bit_end) r_latch <= 1'b0;
        end
        default: r_phase <= '0;
      endcase
    end
  end

endmodule

// File: rtl/led_display_pattern_gen.sv
// Test-pattern generator: scan address, mode-change restart, row build and inter-row hold.
// Handshake: a row transfers in a cycle where o_row_valid and i_row_ready are both high;
// o_row_valid is only ever raised while i_row_ready is high, so valid alone marks the transfer.
module led_display_pattern_gen
  import led_display_package::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int NUM_ROW_PIXELS = 32,
  parameter int SIMULATION     = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [3:0]           i_mode,
  input  logic [2:0]           i_colour,
  input  logic                 i_row_ready,
  output logic                 o_row_valid,
  output rgb_row_t             o_row,
  output logic [GL_ADDR_W-1:0] o_row_addr
);

  localparam int ROW_HOLD = (SIMULATION != 0) ? 0 : SYS_CLK_FREQ / 32_000;
  localparam int HOLD_W   = $clog2(ROW_HOLD + 2);
  localparam logic [GL_ADDR_W-1:0] LAST_ADDR = GL_ADDR_W'(NUM_ROW_PIXELS / 2 - 1);

  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [3:0]           r_mode_q;
  logic [GL_ADDR_W-1:0] r_addr;
  logic                 r_armed;
  logic                 w_hold_expired;
  logic                 w_mode_changed;

  assign w_hold_expired = (r_hold_cnt == '0);
  assign w_mode_changed = (i_mode != r_mode_q);

  // No row is offered in the cycle a mode change is seen, so the next row is address 0 of the new mode.
  assign o_row_valid = r_armed & i_row_ready & w_hold_expired & ~w_mode_changed;
  assign o_row       = '{top: build_half(i_mode, i_colour), bot: build_half(i_mode, i_colour)};
  assign o_row_addr  = r_addr;

  // Address sequencing, mode tracking and hold timer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_cnt <= '0;
      r_mode_q   <= MODE_OFF;
      r_addr     <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_mode_q <= i_mode;
      if (w_mode_changed) begin
        r_addr <= '0;
      end else if (o_row_valid) begin
        r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
      end
      if (o_row_valid) begin
        r_hold_cnt <= HOLD_W'(ROW_HOLD);
      end else if (!w_hold_expired) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_display_pattern_driver.sv
// HUB75 front end: pattern generator feeding the serial row PHY over a valid/ready row handshake.
module led_display_pattern_driver
  import led_display_package::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int BCLK_FREQ      = 21_000_000,
  parameter int NUM_COL_PIXELS = 64,
  parameter int NUM_ROW_PIXELS = 32,
  parameter int SIMULATION     = 0
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [3:0] mode_in,
  input  logic [2:0] colour_in,
  output logic       red_top_out,
  output logic       green_top_out,
  output logic       blue_top_out,
  output logic       red_bot_out,
  output logic       green_bot_out,
  output logic       blue_bot_out,
  output logic       bit_clk_out,
  output logic       latch_out,
  output logic [3:0] row_address_out,
  output logic [1:0] dbg_phy_state_out
);

  logic                 w_row_valid;
  logic                 w_row_ready;
  rgb_row_t             w_row;
  logic [GL_ADDR_W-1:0] w_row_addr;
  logic [5:0]           w_data;

  led_display_pattern_gen #(
    .SYS_CLK_FREQ   (SYS_CLK_FREQ),
    .NUM_ROW_PIXELS (NUM_ROW_PIXELS),
    .SIMULATION     (SIMULATION)
  ) u_gen (
    .i_clk       (clk_in),
    .i_rst       (reset_in),
    .i_mode      (mode_in),
    .i_colour    (colour_in),
    .i_row_ready (w_row_ready),
    .o_row_valid (w_row_valid),
    .o_row       (w_row),
    .o_row_addr  (w_row_addr)
  );

  led_display_driver_phy #(
    .SYS_CLK_FREQ   (SYS_CLK_FREQ),
    .BCLK_FREQ      (BCLK_FREQ),
    .NUM_COL_PIXELS (NUM_COL_PIXELS)
  ) u_phy (
    .i_clk       (clk_in),
    .i_rst       (reset_in),
    .i_row_valid (w_row_valid),
    .i_row       (w_row),
    .i_row_addr  (w_row_addr),
    .o_row_ready (w_row_ready),
    .o_data      (w_data),
    .o_bit_clk   (bit_clk_out),
    .o_latch     (latch_out),
    .o_row_addr  (row_address_out),
    .o_state     (dbg_phy_state_out)
  );

  assign red_top_out   = w_data[0];
  assign green_top_out = w_data[1];
  assign blue_top_out  = w_data[2];
  assign red_bot_out   = w_data[3];
  assign green_bot_out = w_data[4];
  assign blue_bot_out  = w_data[5];

endmodule

// File: tb/tb_led_display_pattern_driver.sv
// Bench: random mode/colour changes between rows, a row-level reference model and a latch-driven monitor.
module tb_led_display_pattern_driver;

  localparam int SYS_CLK_FREQ = 100_000_000;
  localparam int BCLK_FREQ    = 21_000_000;
  localparam int NCOL         = 64;
  localparam int HALF         = (SYS_CLK_FREQ + 2 * BCLK_FREQ - 1) / (2 * BCLK_FREQ);
  localparam int ROW_PERIOD   = 1 + NCOL * 2 * HALF + 2 * HALF;
  localparam int NUM_ITER     = 60;
  localparam int W            = 4 + 6 * NCOL;

  // ---------------- clock / reset / DUT ----------------
  logic       clk_in = 1'b0;
  logic       reset_in = 1'b0;
  logic [3:0] mode_in = 4'd0;
  logic [2:0] colour_in = 3'd0;
  logic       red_top_out, green_top_out, blue_top_out;
  logic       red_bot_out, green_bot_out, blue_bot_out;
  logic       bit_clk_out, latch_out;
  logic [3:0] row_address_out;
  logic [1:0] dbg_phy_state_out;

  always #5 clk_in = ~clk_in;

  led_display_pattern_driver #(
    .SYS_CLK_FREQ   (SYS_CLK_FREQ),
    .BCLK_FREQ      (BCLK_FREQ),
    .NUM_COL_PIXELS (NCOL),
    .NUM_ROW_PIXELS (32),
    .SIMULATION     (1)
  ) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .mode_in           (mode_in),
    .colour_in         (colour_in),
    .red_top_out       (red_top_out),
    .green_top_out     (green_top_out),
    .blue_top_out      (blue_top_out),
    .red_bot_out       (red_bot_out),
    .green_bot_out     (green_bot_out),
    .blue_bot_out      (blue_bot_out),
    .bit_clk_out       (bit_clk_out),
    .latch_out         (latch_out),
    .row_address_out   (row_address_out),
    .dbg_phy_state_out (dbg_phy_state_out)
  );

  wire [5:0] w_data = {blue_bot_out, green_bot_out, red_bot_out,
                       blue_top_out, green_top_out, red_top_out};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_mis = 0;
  string ch_name[6] = '{"red_top", "green_top", "blue_top", "red_bot", "green_bot", "blue_bot"};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s: no DUT event within bound at %0t", name, $time);
  endtask

  // Reference row: what the panel should receive for a mode/colour/address, column by column.
  function automatic logic [W-1:0] model_row(input int mode, input logic [2:0] colour, input int addr);
    logic [W-1:0] e;
    logic c;
    e = '0;
    e[W-1 -: 4] = 4'(addr);
    for (int ch = 0; ch < 6; ch++) begin
      c = colour[ch % 3];
      for (int col = 0; col < NCOL; col++) begin
        if (mode == 1)      e[ch * NCOL + col] = c;
        else if (mode == 2) e[ch * NCOL + col] = (col % 2 == 0) ? c : 1'b0;
        else                e[ch * NCOL + col] = 1'b0;
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0;
  int bit_cnt, last_rise, last_latch, latch_rise, data_chg;
  logic prev_bclk, prev_latch;
  logic [5:0] prev_data;
  logic [6*NCOL-1:0] got;
  logic [W-1:0] e;

  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (reset_in) begin
        bit_cnt = 0; last_rise = -1; last_latch = -1; latch_rise = -1;
        prev_bclk = 1'b0; prev_latch = 1'b0; prev_data = '0; data_chg = cyc; got = '0;
        continue;
      end
      if (w_data != prev_data) data_chg = cyc;
      if (bit_clk_out && !prev_bclk) begin
        check("data_setup", 64'(cyc - data_chg >= HALF), 64'd1);
        if (bit_cnt > 0 && last_rise >= 0) check("bclk_period", 64'(cyc - last_rise), 64'(2 * HALF));
        if (bit_cnt < NCOL)
          for (int ch = 0; ch < 6; ch++) got[ch * NCOL + bit_cnt] = w_data[ch];
        bit_cnt++;
        last_rise = cyc;
      end
      if (latch_out && !prev_latch) begin
        check("bits_per_row", 64'(bit_cnt), 64'(NCOL));
        check("bclk_low_in_latch", 64'(bit_clk_out), 64'd0);
        if (last_latch >= 0) check("row_period", 64'(cyc - last_latch), 64'(ROW_PERIOD));
        check("row_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("row_addr", 64'(row_address_out), 64'(e[W-1 -: 4]));
          for (int ch = 0; ch < 6; ch++)
            check(ch_name[ch], got[ch * NCOL +: NCOL], e[ch * NCOL +: NCOL]);
        end
        bit_cnt = 0; got = '0;
        last_latch = cyc;
        latch_rise = cyc;
      end
      if (!latch_out && prev_latch && latch_rise >= 0)
        check("latch_width", 64'(cyc - latch_rise), 64'(2 * HALF));
      prev_bclk = bit_clk_out; prev_latch = latch_out; prev_data = w_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_latch(output bit ok);
    logic p;
    p = latch_out;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      if (latch_out && !p) begin ok = 1'b1; break; end
      p = latch_out;
    end
    if (!ok) timeout_fail("latch_wait");
  endtask

  task automatic wait_queue_empty();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) begin done = 1'b1; break; end
      @(negedge clk_in);
    end
    if (!done) timeout_fail("rows_drain");
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_data"}, 64'(w_data), 64'd0);
    check({tag, "_bclk"}, 64'(bit_clk_out), 64'd0);
    check({tag, "_latch"}, 64'(latch_out), 64'd0);
    check({tag, "_addr"}, 64'(row_address_out), 64'd0);
    check({tag, "_phy_state"}, 64'(dbg_phy_state_out), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int cur_mode, new_mode, m_addr;
  logic [2:0] cur_colour, new_colour;
  bit ok;

  initial begin
    #1 reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_outputs_reset("reset");
    cur_mode = 0; cur_colour = 3'd0;
    exp_q.push_back(model_row(0, 3'd0, 0));
    exp_q.push_back(model_row(0, 3'd0, 1));
    m_addr = 1;
    reset_in = 1'b0;

    // Each iteration: after row j latches, row j+1 is shifting; new settings apply from row j+2.
    for (int j = 0; j < NUM_ITER; j++) begin
      wait_latch(ok);
      if (!ok) break;
      repeat ($urandom_range(20, 300)) @(negedge clk_in);
      new_mode = cur_mode; new_colour = cur_colour;
      if (j == 16) begin
        new_mode = 1; new_colour = 3'b101;
      end else if (j == 19) begin
        new_mode = 2; new_colour = 3'b010;
      end else if (j == 29) begin
        new_mode = 1; new_colour = 3'($urandom_range(0, 7));
      end else if (j >= 30) begin
        if ($urandom_range(0, 3) == 0) new_mode = $urandom_range(0, 5);
        new_colour = 3'($urandom_range(0, 7));
      end
      m_addr = (new_mode != cur_mode) ? 0 : (m_addr + 1) % 16;
      exp_q.push_back(model_row(new_mode, new_colour, m_addr));
      cur_mode = new_mode; cur_colour = new_colour;
      mode_in = 4'(new_mode); colour_in = new_colour;
    end
    wait_queue_empty();

    // Abort a row mid-shift with an asynchronous reset, then restart from address 0.
    repeat (100) @(negedge clk_in);
    #2 reset_in = 1'b1;
    #1 check_outputs_reset("midrow_reset");
    mode_in = 4'd1;
    colour_in = 3'($urandom_range(0, 7));
    exp_q.push_back(model_row(1, colour_in, 0));
    exp_q.push_back(model_row(1, colour_in, 1));
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    wait_queue_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
    $fatal(1, "watchdog");
  end

endmodule
